// File: rtl/addrunit_queue.sv
// addrunit_queue: address-generation unit with a DEPTH-entry in-order queue.
// Computes vj + imm at enqueue, buffers ops, presents the head combinationally,
// sends loads to the load buffer under valid/ready and reports every op's
// address to the ROB. Stores pop unconditionally; the ROB can flush the queue.
// Optional feature macro: MISALIGN_CHECK_EN (adds addrunit_rob_misalign_out;
// misaligned loads bypass the load buffer and pop like stores).
module addrunit_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int OP_WIDTH   = 6,
  parameter int DEPTH      = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  rs_addrunit_valid_in,
  output logic                  rs_addrunit_ready_out,
  input  logic [OP_WIDTH-1:0]   rs_addrunit_opcode_in,
  input  logic [ADDR_WIDTH-1:0] rs_addrunit_vj_in,
  input  logic [ADDR_WIDTH-1:0] rs_addrunit_a_in,
  input  logic [ROB_WIDTH-1:0]  rs_addrunit_dest_in,
  output logic                  addrunit_lbuffer_en_out,
  input  logic                  lbuffer_addrunit_ready_in,
  output logic [ADDR_WIDTH-1:0] addrunit_lbuffer_a_out,
  output logic [ROB_WIDTH-1:0]  addrunit_lbuffer_dest_out,
  output logic [OP_WIDTH-1:0]   addrunit_lbuffer_opcode_out,
  output logic                  addrunit_rob_en_out,
  output logic [ROB_WIDTH-1:0]  addrunit_rob_h_out,
  output logic [ADDR_WIDTH-1:0] addrunit_rob_address_out,
  input  logic                  rob_addrunit_rst_in
`ifdef MISALIGN_CHECK_EN
  ,
  output logic                  addrunit_rob_misalign_out
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Opcode encoding shared with the reservation station
  localparam logic [OP_WIDTH-1:0] OP_NOP = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_LB  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_LH  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_LW  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_LBU = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_LHU = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SB  = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_SH  = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_SW  = OP_WIDTH'(8);

  logic [OP_WIDTH-1:0]   r_op   [DEPTH];
  logic [ROB_WIDTH-1:0]  r_dest [DEPTH];
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  logic                  w_head_vld;
  logic [OP_WIDTH-1:0]   w_head_op;
  logic                  w_head_is_load;
  logic                  w_head_misalign;
  logic                  w_head_to_lb;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_flush;
  logic                  w_ready;

`ifdef MISALIGN_CHECK_EN
  function automatic logic misaligned(input logic [OP_WIDTH-1:0] op,
                                      input logic [ADDR_WIDTH-1:0] addr);
    logic half;
    logic word;
    half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    word = (op == OP_LW) || (op == OP_SW);
    return (half && addr[0]) || (word && (addr[1:0] != 2'b00));
  endfunction
`endif

  assign w_head_vld     = (r_count != '0);
  assign w_head_op      = r_op[r_head];
  assign w_head_is_load = (w_head_op >= OP_LB) && (w_head_op <= OP_LHU);
`ifdef MISALIGN_CHECK_EN
  assign w_head_misalign = w_head_vld && misaligned(w_head_op, r_addr[r_head]);
`else
  assign w_head_misalign = 1'b0;
`endif
  assign w_head_to_lb = w_head_vld && w_head_is_load && !w_head_misalign;

  // A load waits for the load buffer; everything else leaves as soon as enabled
  assign w_pop   = rdy_in && w_head_vld && (!w_head_to_lb || lbuffer_addrunit_ready_in);
  assign w_flush = rdy_in && rob_addrunit_rst_in;
  assign w_ready = rst_n_in && ((r_count < CNT_W'(DEPTH)) || w_pop);
  assign w_push  = rdy_in && rs_addrunit_valid_in && w_ready &&
                   (rs_addrunit_opcode_in != OP_NOP) && !w_flush;

  assign rs_addrunit_ready_out       = w_ready;
  assign addrunit_lbuffer_en_out     = w_head_to_lb;
  assign addrunit_lbuffer_a_out      = w_head_vld ? r_addr[r_head] : '0;
  assign addrunit_lbuffer_dest_out   = w_head_vld ? r_dest[r_head] : '0;
  assign addrunit_lbuffer_opcode_out = w_head_vld ? w_head_op : '0;
  assign addrunit_rob_en_out         = w_head_vld;
  assign addrunit_rob_h_out          = w_head_vld ? r_dest[r_head] : '0;
  assign addrunit_rob_address_out    = w_head_vld ? r_addr[r_head] : '0;
`ifdef MISALIGN_CHECK_EN
  assign addrunit_rob_misalign_out   = w_head_misalign;
`endif

  // Entry storage: payload only, validity is tracked by the pointers
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_op[r_tail]   <= rs_addrunit_opcode_in;
      r_dest[r_tail] <= rs_addrunit_dest_in;
      r_addr[r_tail] <= rs_addrunit_vj_in + rs_addrunit_a_in;
    end
  end

  // Queue pointers and occupancy; flush wins over any same-cycle push/pop
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: doc/addrunit_queue.md
Name: addrunit_queue

Overview:
Parametrised address-generation unit with a DEPTH-entry in-order queue. It sits between the reservation station and the load buffer / reorder buffer.
- Accepts issued memory ops and computes the effective address vj + imm at enqueue.
- Buffers results and drains them in order.
- Loads go to the load buffer under a valid/ready handshake; every op reports its address to the ROB.
- Unlike the single-cycle combinational predecessor, it tolerates load-buffer backpressure, handles stores explicitly and supports ROB flush.

Parameters:
ADDR_WIDTH, 32, address and operand width
ROB_WIDTH, 4, ROB tag width
OP_WIDTH, 6, opcode width (matches `IDWidth)
DEPTH, 4, queue entries; power of two, >= 2

Ports:
clk_in  in  1  clock
rst_n_in  in  1  asynchronous active-low reset
rdy_in  in  1  global enable; when 0, all state holds and no handshake completes
rs_addrunit_valid_in  in  1  issued op present
rs_addrunit_ready_out  out  1  queue can accept this cycle
rs_addrunit_opcode_in  in  OP_WIDTH  opcode (`NOP, loads `LB..`LHU, stores `SB..`SW)
rs_addrunit_vj_in  in  ADDR_WIDTH  base register value
rs_addrunit_a_in  in  ADDR_WIDTH  sign-extended immediate
rs_addrunit_dest_in  in  ROB_WIDTH  ROB tag
addrunit_lbuffer_en_out  out  1  load valid to load buffer
lbuffer_addrunit_ready_in  in  1  load buffer accepts
addrunit_lbuffer_a_out  out  ADDR_WIDTH  load address
addrunit_lbuffer_dest_out  out  ROB_WIDTH  load ROB tag
addrunit_lbuffer_opcode_out  out  OP_WIDTH  load opcode
addrunit_rob_en_out  out  1  address report valid
addrunit_rob_h_out  out  ROB_WIDTH  reported ROB tag
addrunit_rob_address_out  out  ADDR_WIDTH  reported address
rob_addrunit_rst_in  in  1  synchronous flush from ROB

Behaviour:
- Reset (rst_n_in=0, asynchronous):
  - head, tail and count cleared to 0.
  - All valid/enable outputs 0; data outputs 0; rs_addrunit_ready_out 0 while reset is held.
- Enqueue: fires when rdy_in & rs_addrunit_valid_in & rs_addrunit_ready_out & opcode != `NOP.
  - Entry stores {opcode, dest, vj + a}. The add is modulo 2^ADDR_WIDTH and wraps silently.
  - A NOP with valid high is consumed and discarded; no entry is written.
- rs_addrunit_ready_out = (count < DEPTH) | pop_this_cycle. A push into a full queue is legal in the same cycle as a pop.
- Head presentation: combinational from the head entry when count > 0.
  - Head load: addrunit_lbuffer_en_out=1 and addrunit_rob_en_out=1.
  - Head store: addrunit_lbuffer_en_out=0 and addrunit_rob_en_out=1.
- Pop:
  - Head load: pops when rdy_in & lbuffer_addrunit_ready_in. The ROB report is valid for the cycle the pop completes; the ROB always accepts.
  - Head store: pops unconditionally when rdy_in.
  - At most one pop per cycle.
- Latency: an op enqueued at edge N appears on the outputs after edge N (earliest report in the cycle following acceptance). There is no bypass from input to output.
- Ordering: strictly in order. A stalled head load blocks younger stores.
- Pointers wrap modulo DEPTH. count tracks occupancy 0..DEPTH.
- Flush (rob_addrunit_rst_in=1 with rdy_in=1), evaluated at the next edge:
  - head, tail and count cleared.
  - An enqueue in the same cycle is dropped; a pop in the same cycle has no effect.
  - Outputs are invalid from the following cycle.
- rdy_in=0: no push, no pop and no flush take effect. Outputs still reflect the head entry, but handshakes do not count.
- Reset mid-operation: all entries are lost immediately and no stale valid remains.

Optional Feature:
MISALIGN_CHECK_EN
- Defined:
  - Adds output addrunit_rob_misalign_out (1 bit), valid with addrunit_rob_en_out.
  - Asserts for halfword ops with addr[0]=1 and for word ops with addr[1:0]!=0.
  - A misaligned load is not sent to the load buffer (en_out forced 0); it pops unconditionally like a store.
- Undefined: the port is absent and addresses are forwarded regardless of alignment.

Test Plan:
- Reset release, no input -> all enables 0, ready_out=1, count=0.
- Push LW vj=0x1000 a=0xFFFFFFFC dest=3, lbuffer ready=1 -> next cycle lbuffer_en=1, a_out=0x00000FFC, dest_out=3, rob_en=1, h_out=3; queue empty after.
- Hold lbuffer ready=0, push 5 ops with DEPTH=4 -> 4 accepted, ready_out=0 on the 5th. Raise ready for 1 cycle -> head pops, and the 5th push is accepted in the same cycle.
- Push SW dest=1 behind a stalled LB dest=0 -> SW is not reported until the LB pops; report order is tags 0 then 1.
- Fill 3 entries, assert rob_addrunit_rst_in together with a push -> next cycle all enables 0, count=0, the pushed op is absent.
- With MISALIGN_CHECK_EN: push LH addr 0x1001 -> rob_en=1, misalign_out=1, lbuffer_en=0, popped without ready.
